key_load_ctrl: RTL and testbench
================================

// Module: key_load_ctrl
// PURPOSE
//  Sequences key delivery into the key-locked c17 netlist and its key-MUX insertion points.
//  Fetches KEY_W key bits serially from the key store (NVM) over a req/ack handshake.
//  Assembles the bits, drives the D_* key inputs atomically and flags when the locked
//  outputs are trustworthy. Keeps key inputs at zero whenever no verified key is loaded.
// PARAMETERS
//  KEY_W    2   number of key bits (D_0..D_{KEY_W-1}); >=1
//  SETTLE   2   cycles key must be stable before key_ready; >=1
//  TIMEOUT  15  max consecutive cycles nvm_req may wait without nvm_ack; >=1
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      1-cycle pulse: begin (or restart) key load
//  nvm_req    out  1      request next key bit from key store
//  nvm_ack    in   1      key store: nvm_bit valid this cycle
//  nvm_bit    in   1      serial key bit, LSB (D_0) first
//  key        out  KEY_W  drives D_0..D_{KEY_W-1} of the locked netlist
//  key_ready  out  1      key applied and settled; locked outputs valid
//  busy       out  1      load/settle in progress
//  err        out  1      sticky load timeout, cleared by start or reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; nvm_req=0, key=0, key_ready=0, busy=0, err=0;
//   shift reg, bit_cnt, wait_cnt, settle_cnt all 0. Mid-load reset aborts silently.
//  States: IDLE, FETCH, SETTLE, DONE, ERR. All outputs registered.
//  IDLE: on start -> FETCH; bit_cnt=0, wait_cnt=0, err=0.
//  FETCH: nvm_req=1, busy=1, key=0. Transfer = nvm_req & nvm_ack, one bit per cycle;
//   back-to-back acks allowed. On transfer: shreg[bit_cnt]<=nvm_bit, bit_cnt++, wait_cnt=0.
//   Transfer with bit_cnt==KEY_W-1 -> SETTLE: key<=full assembled word in same edge,
//   nvm_req drops next cycle. No transfer: wait_cnt++; wait_cnt reaching TIMEOUT -> ERR.
//   nvm_ack while nvm_req=0 is ignored.
//  SETTLE: busy=1, key held; settle_cnt counts 1..SETTLE; at SETTLE -> DONE.
//  DONE: key held, key_ready=1, busy=0. start -> FETCH; key and key_ready cleared on that edge.
//  ERR: err=1, key=0, nvm_req=0, busy=0. start -> FETCH (err cleared). Otherwise stays.
//  start while busy (FETCH/SETTLE) is ignored.
//  Latency: key valid 1 cycle after last ack; key_ready rises SETTLE cycles after key.
//  key never shows a partial word: 0 until atomic update, then full word.
//  bit_cnt width clog2(KEY_W)+1; wait_cnt and settle_cnt saturate, never wrap.
// TESTING (KEY_W=2, SETTLE=2, TIMEOUT=15)
//  Basic: start, acks in 2 consecutive cycles with bits 0,1 -> key=2'b10 cycle after
//   2nd ack, key_ready=1 two cycles later, busy low with it.
//  Stalled ack: 5 idle cycles between bits 1 and 1 -> key=2'b11, no err, key=0 during stall.
//  Timeout: start, no ack for 15 cycles -> err=1, key=0, nvm_req=0; start -> err=0, FETCH.
//  Reload: in DONE with key=2'b10, start -> key=0, key_ready=0 next cycle; load 1,0 -> 2'b01.
//  Async reset after first ack -> all outputs 0 immediately; start ignored while busy.
//  Spurious ack in IDLE/DONE with nvm_bit=1 -> no state or key change.

Source files
------------

// File: rtl/key_load_ctrl_if.sv
// ============================================================================
// key_load_ctrl_if : start/NVM handshake and key-output bundle for key_load_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface key_load_ctrl_if #(
    parameter int KEY_W = 2
);
    logic             start;
    logic             nvm_req;
    logic             nvm_ack;
    logic             nvm_bit;
    logic [KEY_W-1:0] key;
    logic             key_ready;
    logic             busy;
    logic             err;

    modport master (
        input  start, nvm_ack, nvm_bit,
        output nvm_req, key, key_ready, busy, err
    );

    modport slave (
        output start, nvm_ack, nvm_bit,
        input  nvm_req, key, key_ready, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/key_load_ctrl.sv
// ============================================================================
// key_load_ctrl : serial key fetch from NVM, atomic key apply, settle and ready
// Rev 1.0
// ============================================================================
`default_nettype none

module key_load_ctrl #(
    parameter int KEY_W   = 2,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 15
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    key_load_ctrl_if.master    bus
);
    localparam int BCW = $clog2(KEY_W) + 1;
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam int SCW = $clog2(SETTLE + 1);

    localparam logic [BCW-1:0] LAST_BIT   = BCW'(KEY_W - 1);
    localparam logic [WCW-1:0] WAIT_LIM   = WCW'(TIMEOUT);
    localparam logic [SCW-1:0] SETTLE_LIM = SCW'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SETTLE = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t           state_q,      state_d;
    logic             nvm_req_q,    nvm_req_d;
    logic [KEY_W-1:0] key_q,        key_d;
    logic             key_ready_q,  key_ready_d;
    logic             busy_q,       busy_d;
    logic             err_q,        err_d;
    logic [KEY_W-1:0] shreg_q,      shreg_d;
    logic [BCW-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [WCW-1:0]   wait_cnt_q,   wait_cnt_d;
    logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;

    logic             w_xfer;
    logic [KEY_W-1:0] w_word;
    logic [WCW-1:0]   w_wait_inc;
    logic [SCW-1:0]   w_settle_inc;

    always_comb begin
        w_xfer = nvm_req_q & bus.nvm_ack;

        // Word as it will look once the incoming bit lands in its slot
        w_word = shreg_q;
        for (int i = 0; i < KEY_W; i++) begin
            if (bit_cnt_q == BCW'(i)) begin
                w_word[i] = bus.nvm_bit;
            end
        end

        w_wait_inc   = (wait_cnt_q == WAIT_LIM)     ? wait_cnt_q   : wait_cnt_q + 1'b1;
        w_settle_inc = (settle_cnt_q == SETTLE_LIM) ? settle_cnt_q : settle_cnt_q + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        nvm_req_d    = nvm_req_q;
        key_d        = key_q;
        key_ready_d  = key_ready_q;
        busy_d       = busy_q;
        err_d        = err_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d      = S_FETCH;
                    nvm_req_d    = 1'b1;
                    busy_d       = 1'b1;
                    key_d        = '0;
                    key_ready_d  = 1'b0;
                    err_d        = 1'b0;
                    shreg_d      = '0;
                    bit_cnt_d    = '0;
                    wait_cnt_d   = '0;
                    settle_cnt_d = '0;
                end
            end

            S_FETCH: begin
                if (w_xfer) begin
                    shreg_d    = w_word;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    wait_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d      = S_SETTLE;
                        key_d        = w_word;
                        nvm_req_d    = 1'b0;
                        settle_cnt_d = '0;
                    end
                end else begin
                    wait_cnt_d = w_wait_inc;
                    if (w_wait_inc == WAIT_LIM) begin
                        state_d   = S_ERR;
                        err_d     = 1'b1;
                        nvm_req_d = 1'b0;
                        busy_d    = 1'b0;
                        key_d     = '0;
                    end
                end
            end

            S_SETTLE: begin
                settle_cnt_d = w_settle_inc;
                if (w_settle_inc == SETTLE_LIM) begin
                    state_d     = S_DONE;
                    key_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                nvm_req_d   = 1'b0;
                key_d       = '0;
                key_ready_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            nvm_req_q    <= 1'b0;
            key_q        <= '0;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            nvm_req_q    <= nvm_req_d;
            key_q        <= key_d;
            key_ready_q  <= key_ready_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign bus.nvm_req   = nvm_req_q;
    assign bus.key       = key_q;
    assign bus.key_ready = key_ready_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_key_load_ctrl.sv
// ============================================================================
// tb_key_load_ctrl : scenario tasks with a queue of expected loaded keys
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_load_ctrl;
    localparam int KEY_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [KEY_W-1:0] exp_q[$];

    key_load_ctrl_if #(.KEY_W(KEY_W)) bus ();

    key_load_ctrl #(.KEY_W(KEY_W), .SETTLE(2), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for key_ready; no comparison here
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.key_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Start a load and deliver the bits back-to-back, recording the expected word
    task automatic load_bits(input logic [KEY_W-1:0] bits);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < KEY_W; i++) begin
            bus.nvm_ack = 1'b1; bus.nvm_bit = bits[i]; step();
        end
        bus.nvm_ack = 1'b0; bus.nvm_bit = 1'b0;
        exp_q.push_back(bits);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({bus.nvm_req, bus.key, bus.key_ready, bus.busy, bus.err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {bus.nvm_req, bus.key, bus.key_ready, bus.busy, bus.err});
        end
        step(); step();
        rst_n = 1'b1;
        step();
        // Spurious acks in IDLE must be ignored
        bus.nvm_ack = 1'b1; bus.nvm_bit = 1'b1;
        step(); step(); step();
        bus.nvm_ack = 1'b0; bus.nvm_bit = 1'b0;
        checks++;
        if ({bus.nvm_req, bus.key, bus.key_ready, bus.busy, bus.err} !== 6'b0) begin
            failures++;
            $display("FAIL idle_spurious_ack got=%b want=000000",
                     {bus.nvm_req, bus.key, bus.key_ready, bus.busy, bus.err});
        end
    endtask

    task automatic test_basic();
        logic [KEY_W-1:0] exp;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        checks++;
        if ({bus.nvm_req, bus.busy, bus.key} !== 4'b1100) begin
            failures++;
            $display("FAIL basic_fetch_entry got=%b want=1100", {bus.nvm_req, bus.busy, bus.key});
        end
        bus.nvm_ack = 1'b1; bus.nvm_bit = 1'b0; step();
        checks++;
        if (bus.key !== 2'b00) begin
            failures++;
            $display("FAIL basic_no_partial got=%b want=00", bus.key);
        end
        bus.nvm_bit = 1'b1; step();
        exp_q.push_back(2'b10);
        bus.nvm_ack = 1'b0; bus.nvm_bit = 1'b0;
        checks++;
        if ({bus.key, bus.key_ready, bus.busy, bus.nvm_req} !== 5'b10010) begin
            failures++;
            $display("FAIL basic_key_latency got=%b want=10010",
                     {bus.key, bus.key_ready, bus.busy, bus.nvm_req});
        end
        step();
        checks++;
        if (bus.key_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready_early got=%b want=0", bus.key_ready);
        end
        step();
        checks++;
        if ({bus.key_ready, bus.busy} !== 2'b10) begin
            failures++;
            $display("FAIL basic_ready_settle got=%b want=10", {bus.key_ready, bus.busy});
        end
        exp = exp_q.pop_front();
        checks++;
        if (bus.key !== exp) begin
            failures++;
            $display("FAIL basic_key got=%b want=%b", bus.key, exp);
        end
        // Spurious acks in DONE must be ignored
        bus.nvm_ack = 1'b1; bus.nvm_bit = 1'b1;
        step(); step(); step();
        bus.nvm_ack = 1'b0; bus.nvm_bit = 1'b0;
        checks++;
        if ({bus.key, bus.key_ready, bus.busy, bus.nvm_req} !== 5'b10100) begin
            failures++;
            $display("FAIL done_spurious_ack got=%b want=10100",
                     {bus.key, bus.key_ready, bus.busy, bus.nvm_req});
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit bad;
        logic [KEY_W-1:0] exp;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.nvm_ack = 1'b1; bus.nvm_bit = 1'b1; step();
        bus.nvm_ack = 1'b0; bus.nvm_bit = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.key !== 2'b00 || bus.err !== 1'b0 || bus.nvm_req !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL stall_hold key=%b err=%b req=%b want key=00 err=0 req=1",
                     bus.key, bus.err, bus.nvm_req);
        end
        bus.nvm_ack = 1'b1; bus.nvm_bit = 1'b1; step();
        exp_q.push_back(2'b11);
        bus.nvm_ack = 1'b0; bus.nvm_bit = 1'b0;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_ready_wait got=timeout want=key_ready");
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.key !== exp || bus.err !== 1'b0) begin
                failures++;
                $display("FAIL stall_key got=%b err=%b want=%b err=0", bus.key, bus.err, exp);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [KEY_W-1:0] exp;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < 14; i++) step();
        checks++;
        if ({bus.err, bus.nvm_req} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_early got err,req=%b want=01", {bus.err, bus.nvm_req});
        end
        step();
        checks++;
        if ({bus.err, bus.key, bus.nvm_req, bus.busy} !== 5'b10000) begin
            failures++;
            $display("FAIL timeout_err got=%b want=10000",
                     {bus.err, bus.key, bus.nvm_req, bus.busy});
        end
        step(); step();
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b want=1", bus.err);
        end
        bus.start = 1'b1; step(); bus.start = 1'b0;
        checks++;
        if ({bus.err, bus.nvm_req, bus.busy} !== 3'b011) begin
            failures++;
            $display("FAIL timeout_restart got=%b want=011", {bus.err, bus.nvm_req, bus.busy});
        end
        bus.nvm_ack = 1'b1; bus.nvm_bit = 1'b0; step();
        bus.nvm_bit = 1'b1; step();
        exp_q.push_back(2'b10);
        bus.nvm_ack = 1'b0; bus.nvm_bit = 1'b0;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_reload_wait got=timeout want=key_ready");
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.key !== exp) begin
                failures++;
                $display("FAIL timeout_reload_key got=%b want=%b", bus.key, exp);
            end
        end
    endtask

    task automatic test_reload();
        bit ok;
        logic [KEY_W-1:0] exp;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        checks++;
        if ({bus.key, bus.key_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reload_clear got=%b want=000", {bus.key, bus.key_ready});
        end
        bus.nvm_ack = 1'b1; bus.nvm_bit = 1'b1; step();
        bus.nvm_bit = 1'b0; step();
        exp_q.push_back(2'b01);
        bus.nvm_ack = 1'b0;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reload_wait got=timeout want=key_ready");
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.key !== exp) begin
                failures++;
                $display("FAIL reload_key got=%b want=%b", bus.key, exp);
            end
        end
    endtask

    task automatic test_busy_start();
        bit ok;
        logic [KEY_W-1:0] exp;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.nvm_ack = 1'b1; bus.nvm_bit = 1'b1; step();
        bus.nvm_ack = 1'b0; bus.nvm_bit = 1'b0;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        // A restart would have discarded the first bit and left key at 0
        bus.nvm_ack = 1'b1; bus.nvm_bit = 1'b0; step();
        exp_q.push_back(2'b01);
        bus.nvm_ack = 1'b0;
        checks++;
        if ({bus.key, bus.busy} !== 3'b011) begin
            failures++;
            $display("FAIL busy_start_ignored got=%b want=011", {bus.key, bus.busy});
        end
        wait_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL busy_start_wait got=timeout want=key_ready");
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.key !== exp) begin
                failures++;
                $display("FAIL busy_start_key got=%b want=%b", bus.key, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [KEY_W-1:0] exp;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.nvm_ack = 1'b1; bus.nvm_bit = 1'b1; step();
        bus.nvm_ack = 1'b0; bus.nvm_bit = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.nvm_req, bus.key, bus.key_ready, bus.busy, bus.err} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset got=%b want=000000",
                     {bus.nvm_req, bus.key, bus.key_ready, bus.busy, bus.err});
        end
        step();
        rst_n = 1'b1;
        step();
        load_bits(2'b11);
        wait_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL post_reset_wait got=timeout want=key_ready");
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.key !== exp) begin
                failures++;
                $display("FAIL post_reset_key got=%b want=%b", bus.key, exp);
            end
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.nvm_ack = 1'b0;
        bus.nvm_bit = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_reload();
        test_busy_start();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=hang want=finish");
        $fatal(1, "simulation time limit");
    end
endmodule

`default_nettype wire
